// File: rtl/flag_pkg.sv
// flag_pkg
//   Shared definitions for the processor status-flag block.
//   Flag index constants: branch and condition logic should index
//   flags_out only through these names, so the bit layout can change
//   in one place.
//   NFLAGS_BASE is the default flag count of the register.
package flag_pkg;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 3;

  localparam int NFLAGS_BASE = 4;

endpackage : flag_pkg

// File: rtl/flag_lifo.sv
// flag_lifo
//   LIFO shadow stack that holds saved flag vectors.
//   It contains the storage array, the occupancy counter, the full and
//   empty decode, and the detection of illegal operations.
//   The storage array has no reset. Entries above sp are never read.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset (clears sp only)
//   push, pop  : stack operation requests
//   wr_data    : vector stored on a legal push
//   push_ok    : this cycle's push is accepted
//   pop_ok     : this cycle's pop is accepted
//   illegal    : push when full, pop when empty, or push and pop together
//   top_data   : entry at sp-1 (zero when the stack is empty)
//   sp         : number of occupied entries, 0..DEPTH
//   empty/full : decoded from the registered sp
module flag_lifo
  import flag_pkg::*;
#(
  parameter int WIDTH = NFLAGS_BASE,
  parameter int DEPTH = 4,
  localparam int SPW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic             push_ok,
  output logic             pop_ok,
  output logic             illegal,
  output logic [WIDTH-1:0] top_data,
  output logic [SPW-1:0]   sp,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [SPW-1:0]   sp_q;
  logic [SPW-1:0]   sp_d;

  // A push together with a pop is treated as illegal. Neither operation
  // is allowed to change the stack in that case.
  always_comb begin
    empty   = (sp_q == '0);
    full    = (sp_q == SPW'(DEPTH));
    push_ok = push && !pop && !full;
    pop_ok  = pop && !push && !empty;
    illegal = (push && pop) || (push && full) || (pop && empty);
  end

  // Slot selection compares sp against each index. This avoids indexing
  // the array with sp, which is one bit wider than the slot address and
  // can hold DEPTH.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (push_ok && (sp_q == SPW'(i))) begin
        mem_d[i] = wr_data;
      end
    end
  end

  always_comb begin
    top_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_q == SPW'(i + 1)) begin
        top_data = mem_q[i];
      end
    end
  end

  always_comb begin
    sp_d = sp_q;
    if (push_ok) begin
      sp_d = sp_q + SPW'(1);
    end else if (pop_ok) begin
      sp_d = sp_q - SPW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign sp = sp_q;

endmodule : flag_lifo

// File: rtl/flag_stack_regs.sv
// flag_stack_regs
//   Processor status-flag register with a per-bit write mask and a LIFO
//   shadow stack. The stack saves and restores the whole flag vector
//   across interrupt entry and return, and across nested calls.
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_en       : write flags_in into the live flags, under wr_mask
//   wr_mask     : per-bit write enable
//   flags_in    : new flag values from the ALU
//   push, pop   : save or restore the live flags (from the interrupt controller)
//   err_clr     : clear the sticky error
//   flags_out   : live flags (registered)
//   sp          : occupied stack entries
//   stack_empty : sp == 0
//   stack_full  : sp == DEPTH
//   err         : sticky illegal-stack-operation flag
module flag_stack_regs
  import flag_pkg::*;
#(
  parameter int NFLAGS = NFLAGS_BASE,
  parameter int DEPTH  = 4,
  localparam int SPW   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [NFLAGS-1:0] wr_mask,
  input  logic [NFLAGS-1:0] flags_in,
  input  logic              push,
  input  logic              pop,
  input  logic              err_clr,
  output logic [NFLAGS-1:0] flags_out,
  output logic [SPW-1:0]    sp,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              err
);

  logic [NFLAGS-1:0] flags_q;
  logic [NFLAGS-1:0] flags_d;
  logic              err_q;
  logic              err_d;
  logic              push_ok;
  logic              pop_ok;
  logic              illegal;
  logic [NFLAGS-1:0] top_data;

  // The stack always captures flags_q, which is the value before any
  // same-cycle write. This lets interrupt entry save the old flags and
  // clear them in the same cycle.
  flag_lifo #(
    .WIDTH(NFLAGS),
    .DEPTH(DEPTH)
  ) u_lifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (flags_q),
    .push_ok (push_ok),
    .pop_ok  (pop_ok),
    .illegal (illegal),
    .top_data(top_data),
    .sp      (sp),
    .empty   (stack_empty),
    .full    (stack_full)
  );

  // A restore overrides the masked write. Illegal stack operations
  // still let the write through.
  always_comb begin
    flags_d = flags_q;
    if (pop_ok) begin
      flags_d = top_data;
    end else if (wr_en) begin
      flags_d = (flags_q & ~wr_mask) | (flags_in & wr_mask);
    end
  end

  // If an error event and err_clr arrive in the same cycle, the error
  // wins and err stays set.
  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (illegal) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign flags_out = flags_q;
  assign err       = err_q;

endmodule : flag_stack_regs

// File: tb/tb_flag_stack_regs.sv
// tb_flag_stack_regs
//   Testbench for flag_stack_regs with NFLAGS = 4 and DEPTH = 4.
//   A reference model built on a queue predicts every output.
//   The stimulus is the directed sequence followed by a random run.
module tb_flag_stack_regs;
  import flag_pkg::*;

  localparam int NF = 4;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [NF-1:0] wr_mask;
  logic [NF-1:0] flags_in;
  logic          push;
  logic          pop;
  logic          err_clr;
  logic [NF-1:0] flags_out;
  logic [2:0]    sp;
  logic          stack_empty;
  logic          stack_full;
  logic          err;

  int compareCount  = 0;
  int mismatchCount = 0;

  // Reference state: live flags, saved vectors in a queue, sticky error
  logic [NF-1:0] modelFlags;
  logic [NF-1:0] modelStack[$];
  logic          modelErr;

  flag_stack_regs #(
    .NFLAGS(NF),
    .DEPTH (DP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_mask    (wr_mask),
    .flags_in   (flags_in),
    .push       (push),
    .pop        (pop),
    .err_clr    (err_clr),
    .flags_out  (flags_out),
    .sp         (sp),
    .stack_empty(stack_empty),
    .stack_full (stack_full),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_flags"}, 32'(flags_out), 32'(modelFlags));
    checkOutput({tag, "_sp"},    32'(sp),        32'(modelStack.size()));
    checkOutput({tag, "_empty"}, 32'(stack_empty), 32'(modelStack.size() == 0));
    checkOutput({tag, "_full"},  32'(stack_full),  32'(modelStack.size() == DP));
    checkOutput({tag, "_err"},   32'(err),       32'(modelErr));
  endtask

  // Apply one cycle of inputs and advance the model by the same cycle.
  // The outputs are then checked 1 time unit after the clock edge.
  task automatic applyStimulus(input string tag, input logic we, input logic [NF-1:0] msk,
                               input logic [NF-1:0] fin, input logic pu, input logic po,
                               input logic clr);
    logic [NF-1:0] nextFlags;
    logic          bad;
    int            depthNow;
    wr_en    = we;
    wr_mask  = msk;
    flags_in = fin;
    push     = pu;
    pop      = po;
    err_clr  = clr;
    @(posedge clk);
    depthNow  = modelStack.size();
    bad       = (pu && po) || (pu && depthNow == DP) || (po && depthNow == 0);
    nextFlags = modelFlags;
    for (int i = 0; i < NF; i++) begin
      if (we && msk[i]) nextFlags[i] = fin[i];
    end
    if (pu && !po && depthNow < DP) modelStack.push_back(modelFlags);
    if (po && !pu && depthNow > 0) nextFlags = modelStack.pop_back();
    modelFlags = nextFlags;
    if (bad) modelErr = 1'b1;
    else if (clr) modelErr = 1'b0;
    #1;
    checkAll(tag);
  endtask

  initial begin
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_mask  = '0;
    flags_in = '0;
    push     = 1'b0;
    pop      = 1'b0;
    err_clr  = 1'b0;
    modelFlags = '0;
    modelErr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic live writes
    applyStimulus("wr_all", 1, 4'b1111, 4'b1010, 0, 0, 0);
    checkOutput("wr_all_const", 32'(flags_out), 32'h0000000a);
    applyStimulus("wr_mask", 1, 4'b0011, 4'b0101, 0, 0, 0);
    checkOutput("wr_mask_const", 32'(flags_out), 32'h00000009);
    checkOutput("wr_mask_flagz", 32'(flags_out[FLAG_Z]), 32'd1);
    checkOutput("wr_mask_flagc", 32'(flags_out[FLAG_C]), 32'd1);

    // Save and clear in one cycle, then a restore that drops the write
    applyStimulus("push_clr", 1, 4'b1111, 4'b0000, 1, 0, 0);
    checkOutput("push_clr_const", 32'(flags_out), 32'h00000000);
    applyStimulus("pop_rest", 1, 4'b1111, 4'b1111, 0, 1, 0);
    checkOutput("pop_rest_const", 32'(flags_out), 32'h00000009);

    // Fill the stack, overflow it, then drain it
    applyStimulus("ld1", 1, 4'b1111, 4'b0001, 0, 0, 0);
    applyStimulus("ps1", 1, 4'b1111, 4'b0010, 1, 0, 0);
    applyStimulus("ps2", 1, 4'b1111, 4'b0100, 1, 0, 0);
    applyStimulus("ps3", 1, 4'b1111, 4'b1000, 1, 0, 0);
    applyStimulus("ps4", 0, 4'b0000, 4'b0000, 1, 0, 0);
    checkOutput("full_const", 32'(stack_full), 32'd1);
    applyStimulus("ps5_ovf", 0, 4'b0000, 4'b0000, 1, 0, 0);
    checkOutput("ovf_sp_const", 32'(sp), 32'd4);
    for (int i = 0; i < 4; i++) applyStimulus($sformatf("drain%0d", i), 0, 0, 0, 0, 1, 0);
    checkOutput("drain_last_const", 32'(flags_out), 32'h00000001);
    checkOutput("drain_empty_const", 32'(stack_empty), 32'd1);

    // Error behaviour on an empty stack
    applyStimulus("clr0", 0, 0, 0, 0, 0, 1);
    applyStimulus("pop_empty", 0, 0, 0, 0, 1, 0);
    applyStimulus("err_clr", 0, 0, 0, 0, 0, 1);
    applyStimulus("pushpop", 1, 4'b0110, 4'b0110, 1, 1, 0);
    applyStimulus("err_clr2", 0, 0, 0, 0, 0, 1);
    applyStimulus("pushpop_clr", 0, 0, 0, 1, 1, 1);
    checkOutput("pushpop_clr_const", 32'(err), 32'd1);

    // Asynchronous reset in the middle of a cycle with sp = 3
    for (int i = 0; i < 3; i++) applyStimulus($sformatf("pre_rst%0d", i), 1, 4'b1111, NF'(i + 5), 1, 0, 0);
    applyStimulus("pre_rst_err", 0, 0, 0, 1, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    modelFlags = '0;
    modelStack.delete();
    modelErr = 1'b0;
    checkAll("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Random run against the model
    for (int n = 0; n < 400; n++) begin
      int r;
      logic pu;
      logic po;
      r  = int'($urandom_range(0, 99));
      pu = (r < 35) || (r >= 95);
      po = (r >= 35 && r < 70) || (r >= 95);
      applyStimulus($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), NF'($urandom),
                    NF'($urandom), pu, po, ($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule : tb_flag_stack_regs
